rx_byte_assembler: RTL and testbench

RX_BYTE_ASSEMBLER -- requirements
Module: rx_byte_assembler

---
 rtl/rx_pkg.sv | 23 ++
 rtl/rx_byte_assembler_if.sv | 34 +++
 rtl/rx_unstuffer.sv | 44 ++++
 rtl/rx_byte_assembler.sv | 142 ++++++++++++++
 tb/tb_rx_byte_assembler.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/rx_pkg.sv
// -----------------------------------------------------------------------------
// rx_pkg
// Shared definitions for the receive byte assembler: FSM state encoding,
// sync pattern, bit-stuffing run limit and sync search timeout.
// -----------------------------------------------------------------------------
package rx_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SYNC,
      DATA,
      EOP_WAIT,
      ERROR
   } rx_state_t;

   // Sync byte as it appears in shift_reg after right-shift assembly
   localparam logic [7:0]  SYNC_BYTE    = 8'h80;
   // Run of ones after which the next bit is a stuffed zero
   localparam int unsigned MAX_ONES     = 6;
   // Bits allowed in SYNC before giving up on the packet
   localparam int unsigned SYNC_TIMEOUT = 16;

endpackage

// File: rtl/rx_byte_assembler_if.sv
// -----------------------------------------------------------------------------
// rx_byte_assembler_if
// Bit stream from the upstream NRZI decoder and the assembled byte/status
// outputs of the receive byte assembler.
//   d_orig, shift_enable, eop : decoder -> assembler (one bit per shift_enable)
//   rx_data, byte_ready       : assembled byte and its one-cycle strobe
//   sync_found, packet_done   : one-cycle event pulses
//   rx_error                  : sticky error level
//   receiving                 : packet in progress (SYNC/DATA/ERROR)
// master = decoder side, slave = assembler side.
// -----------------------------------------------------------------------------
interface rx_byte_assembler_if;

   logic       d_orig;
   logic       shift_enable;
   logic       eop;
   logic [7:0] rx_data;
   logic       byte_ready;
   logic       sync_found;
   logic       packet_done;
   logic       rx_error;
   logic       receiving;

   modport master (
      output d_orig, shift_enable, eop,
      input  rx_data, byte_ready, sync_found, packet_done, rx_error, receiving
   );

   modport slave (
      input  d_orig, shift_enable, eop,
      output rx_data, byte_ready, sync_found, packet_done, rx_error, receiving
   );

endinterface

// File: rtl/rx_unstuffer.sv
// -----------------------------------------------------------------------------
// rx_unstuffer
// Tracks the run of consecutive ones in the data phase and flags the bit
// following MAX_ONES ones as a stuff bit.
//   clk, rst   : clock, synchronous active-high reset
//   bit_in     : current decoded bit
//   adv        : a data-phase bit is being processed this cycle
//   sync_load  : sync just matched; its trailing one starts the run
//   bit_keep   : current bit is payload (not a stuff bit)
//   stuff_err  : current bit is in the stuff slot but is a one
// -----------------------------------------------------------------------------
module rx_unstuffer
   import rx_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic bit_in,
   input  logic adv,
   input  logic sync_load,
   output logic bit_keep,
   output logic stuff_err
);

   localparam logic [2:0] ONES_LIMIT = 3'(MAX_ONES);

   logic [2:0] ones_cnt;

   assign bit_keep  = (ones_cnt != ONES_LIMIT);
   assign stuff_err = !bit_keep && bit_in;

   // A kept one can only arrive while ones_cnt < ONES_LIMIT, so the
   // increment saturates at ONES_LIMIT without an explicit clamp.
   always_ff @(posedge clk) begin
      if (rst) begin
         ones_cnt <= '0;
      end else if (sync_load) begin
         ones_cnt <= 3'd1;
      end else if (adv) begin
         if (!bit_keep || !bit_in) ones_cnt <= '0;
         else                      ones_cnt <= ones_cnt + 3'd1;
      end
   end

endmodule

// File: rtl/rx_byte_assembler.sv
// -----------------------------------------------------------------------------
// rx_byte_assembler
// Hunts for the sync pattern in the decoded bit stream, removes stuff bits,
// assembles LSB-first bytes and reports end of packet and errors.
//   clk  : system clock, all state on rising edge
//   rst  : synchronous active-high reset
//   bus  : rx_byte_assembler_if.slave (decoder bits in, byte/status out)
// All outputs except receiving are registered (one cycle after shift_enable).
// -----------------------------------------------------------------------------
module rx_byte_assembler
   import rx_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   rx_byte_assembler_if.slave    bus
);

   rx_state_t  state, state_n;
   logic [7:0] shift_reg, shift_reg_n;
   logic [4:0] bit_cnt, bit_cnt_n;
   logic [7:0] rx_data_q, rx_data_n;
   logic       byte_ready_q, byte_ready_n;
   logic       sync_found_q, sync_found_n;
   logic       packet_done_q, packet_done_n;
   logic       rx_error_q, rx_error_n;

   logic [7:0] shifted;
   logic [4:0] cnt_inc;
   logic       adv, bit_keep, stuff_err;

   assign shifted = {bus.d_orig, shift_reg[7:1]};
   assign cnt_inc = bit_cnt + 5'd1;
   assign adv     = (state == DATA) && bus.shift_enable && !bus.eop;

   rx_unstuffer u_unstuffer (
      .clk       (clk),
      .rst       (rst),
      .bit_in    (bus.d_orig),
      .adv       (adv),
      .sync_load (sync_found_n),
      .bit_keep  (bit_keep),
      .stuff_err (stuff_err)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         shift_reg     <= '0;
         bit_cnt       <= '0;
         rx_data_q     <= '0;
         byte_ready_q  <= 1'b0;
         sync_found_q  <= 1'b0;
         packet_done_q <= 1'b0;
         rx_error_q    <= 1'b0;
      end else begin
         state         <= state_n;
         shift_reg     <= shift_reg_n;
         bit_cnt       <= bit_cnt_n;
         rx_data_q     <= rx_data_n;
         byte_ready_q  <= byte_ready_n;
         sync_found_q  <= sync_found_n;
         packet_done_q <= packet_done_n;
         rx_error_q    <= rx_error_n;
      end
   end

   always_comb begin
      state_n       = state;
      shift_reg_n   = shift_reg;
      bit_cnt_n     = bit_cnt;
      rx_data_n     = rx_data_q;
      byte_ready_n  = 1'b0;
      sync_found_n  = 1'b0;
      packet_done_n = 1'b0;
      rx_error_n    = rx_error_q;

      if (bus.shift_enable) begin
         unique case (state)
            IDLE: begin
               if (!bus.eop && !bus.d_orig) begin
                  state_n     = SYNC;
                  shift_reg_n = shifted;
                  bit_cnt_n   = 5'd1;
               end
            end
            SYNC: begin
               if (bus.eop) begin
                  rx_error_n = 1'b1;
                  state_n    = EOP_WAIT;
               end else begin
                  shift_reg_n = shifted;
                  bit_cnt_n   = cnt_inc;
                  if (cnt_inc >= 5'd8 && shifted == SYNC_BYTE) begin
                     sync_found_n = 1'b1;
                     rx_error_n   = 1'b0;
                     state_n      = DATA;
                     bit_cnt_n    = '0;
                  end else if (cnt_inc >= 5'(SYNC_TIMEOUT)) begin
                     rx_error_n = 1'b1;
                     state_n    = ERROR;
                  end
               end
            end
            DATA: begin
               if (bus.eop) begin
                  if (bit_cnt == '0) packet_done_n = 1'b1;
                  else               rx_error_n    = 1'b1;
                  state_n = EOP_WAIT;
               end else if (stuff_err) begin
                  rx_error_n = 1'b1;
                  state_n    = ERROR;
               end else if (bit_keep) begin
                  // Byte position wraps 7 -> 0; the 8th bit completes the byte
                  shift_reg_n = shifted;
                  if (bit_cnt[2:0] == 3'd7) begin
                     bit_cnt_n    = '0;
                     rx_data_n    = shifted;
                     byte_ready_n = 1'b1;
                  end else begin
                     bit_cnt_n = cnt_inc;
                  end
               end
            end
            EOP_WAIT: begin
               if (!bus.eop) state_n = IDLE;
            end
            ERROR: begin
               if (bus.eop) state_n = EOP_WAIT;
            end
            default: state_n = IDLE;
         endcase
      end
   end

   assign bus.rx_data     = rx_data_q;
   assign bus.byte_ready  = byte_ready_q;
   assign bus.sync_found  = sync_found_q;
   assign bus.packet_done = packet_done_q;
   assign bus.rx_error    = rx_error_q;
   assign bus.receiving   = (state == SYNC) || (state == DATA) || (state == ERROR);

endmodule

// File: tb/tb_rx_byte_assembler.sv
// -----------------------------------------------------------------------------
// tb_rx_byte_assembler
// Directed bench for rx_byte_assembler: sync detection, byte assembly,
// unstuffing, stuff error, partial-byte EOP, mid-packet reset, sync timeout.
// -----------------------------------------------------------------------------
module tb_rx_byte_assembler;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   rx_byte_assembler_if bus ();

   rx_byte_assembler dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int unsigned tests = 0;
   int unsigned fails = 0;
   int unsigned br_cnt = 0;
   int unsigned pd_cnt = 0;
   int unsigned overlap_cnt = 0;
   int unsigned br0;
   int unsigned pd0;

   always @(posedge clk) begin
      if (bus.byte_ready)                    br_cnt++;
      if (bus.packet_done)                   pd_cnt++;
      if (bus.byte_ready && bus.packet_done) overlap_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // One decoded bit: shift_enable high for exactly one cycle, then returns
   // on the following falling edge with the resulting outputs visible.
   task automatic send_bit(input logic d, input logic e);
      @(negedge clk);
      bus.d_orig       = d;
      bus.eop          = e;
      bus.shift_enable = 1'b1;
      @(negedge clk);
      bus.shift_enable = 1'b0;
      bus.eop          = 1'b0;
   endtask

   task automatic send_sync();
      repeat (7) send_bit(1'b0, 1'b0);
      send_bit(1'b1, 1'b0);
   endtask

   task automatic send_byte(input logic [7:0] b);
      for (int i = 0; i < 8; i++) send_bit(b[i], 1'b0);
   endtask

   initial begin
      bus.d_orig       = 1'b0;
      bus.eop          = 1'b0;
      bus.shift_enable = 1'b0;
      rst              = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;

      // Reset state
      check("rst_rx_data",     32'(bus.rx_data),     32'h00);
      check("rst_byte_ready",  32'(bus.byte_ready),  0);
      check("rst_sync_found",  32'(bus.sync_found),  0);
      check("rst_packet_done", 32'(bus.packet_done), 0);
      check("rst_rx_error",    32'(bus.rx_error),    0);
      check("rst_receiving",   32'(bus.receiving),   0);

      // Sync with leading idle ones: 1,1,0,0,0,0,0,0,0,1
      send_bit(1'b1, 1'b0);
      check("idle_one_stays", 32'(bus.receiving), 0);
      send_bit(1'b1, 1'b0);
      send_bit(1'b0, 1'b0);
      check("sync_enter", 32'(bus.receiving), 1);
      repeat (6) send_bit(1'b0, 1'b0);
      check("sync_not_yet", 32'(bus.sync_found), 0);
      send_bit(1'b1, 1'b0);
      check("sync_found",      32'(bus.sync_found), 1);
      check("sync_rx_error",   32'(bus.rx_error),   0);
      check("sync_receiving",  32'(bus.receiving),  1);
      @(negedge clk);
      check("sync_pulse_1cyc", 32'(bus.sync_found), 0);
      send_bit(1'b0, 1'b1);
      check("empty_pkt_done",  32'(bus.packet_done), 1);
      check("eop_wait_recv",   32'(bus.receiving),   0);
      send_bit(1'b0, 1'b0);

      // Byte 0xA5 then clean EOP
      br0 = br_cnt;
      pd0 = pd_cnt;
      send_sync();
      send_byte(8'hA5);
      check("a5_byte_ready", 32'(bus.byte_ready), 1);
      check("a5_rx_data",    32'(bus.rx_data),    32'hA5);
      send_bit(1'b0, 1'b1);
      check("a5_packet_done", 32'(bus.packet_done), 1);
      check("a5_no_br_at_pd", 32'(bus.byte_ready),  0);
      check("a5_rx_data_hold", 32'(bus.rx_data),    32'hA5);
      check("a5_rx_error",    32'(bus.rx_error),    0);
      send_bit(1'b0, 1'b0);
      @(negedge clk);
      check("a5_br_count", br_cnt - br0, 1);
      check("a5_pd_count", pd_cnt - pd0, 1);

      // 0xFF with stuffed zero after the sixth consecutive one (sync's trailing one counts)
      send_sync();
      repeat (5) send_bit(1'b1, 1'b0);
      send_bit(1'b0, 1'b0);
      repeat (3) send_bit(1'b1, 1'b0);
      check("ff_byte_ready", 32'(bus.byte_ready), 1);
      check("ff_rx_data",    32'(bus.rx_data),    32'hFF);
      check("ff_rx_error",   32'(bus.rx_error),   0);
      send_bit(1'b0, 1'b1);
      check("ff_packet_done", 32'(bus.packet_done), 1);
      send_bit(1'b0, 1'b0);

      // Stuff error: a one where a stuffed zero belongs
      br0 = br_cnt;
      send_sync();
      repeat (7) send_bit(1'b1, 1'b0);
      check("stf_rx_error",  32'(bus.rx_error),  1);
      check("stf_receiving", 32'(bus.receiving), 1);
      send_bit(1'b0, 1'b1);
      check("stf_eop_wait",  32'(bus.receiving),   0);
      check("stf_no_pd",     32'(bus.packet_done), 0);
      send_bit(1'b0, 1'b0);
      check("stf_idle",      32'(bus.receiving), 0);
      check("stf_err_sticky", 32'(bus.rx_error), 1);
      @(negedge clk);
      check("stf_br_count", br_cnt - br0, 0);

      // Partial byte then EOP
      br0 = br_cnt;
      pd0 = pd_cnt;
      send_sync();
      check("part_err_cleared", 32'(bus.rx_error), 0);
      send_bit(1'b1, 1'b0);
      send_bit(1'b0, 1'b0);
      send_bit(1'b1, 1'b0);
      send_bit(1'b0, 1'b1);
      check("part_rx_error", 32'(bus.rx_error),    1);
      check("part_no_pd",    32'(bus.packet_done), 0);
      send_bit(1'b0, 1'b0);
      @(negedge clk);
      check("part_br_count", br_cnt - br0, 0);
      check("part_pd_count", pd_cnt - pd0, 0);

      // Reset mid-packet, then a fresh 0x3C packet
      br0 = br_cnt;
      pd0 = pd_cnt;
      send_sync();
      send_bit(1'b1, 1'b0);
      send_bit(1'b1, 1'b0);
      send_bit(1'b0, 1'b0);
      send_bit(1'b1, 1'b0);
      @(negedge clk);
      rst              = 1'b1;
      bus.shift_enable = 1'b1;
      bus.d_orig       = 1'b0;
      @(negedge clk);
      rst              = 1'b0;
      bus.shift_enable = 1'b0;
      check("mr_rx_data",     32'(bus.rx_data),     32'h00);
      check("mr_rx_error",    32'(bus.rx_error),    0);
      check("mr_receiving",   32'(bus.receiving),   0);
      check("mr_byte_ready",  32'(bus.byte_ready),  0);
      check("mr_packet_done", 32'(bus.packet_done), 0);
      check("mr_sync_found",  32'(bus.sync_found),  0);
      @(negedge clk);
      check("mr_br_count", br_cnt - br0, 0);
      check("mr_pd_count", pd_cnt - pd0, 0);
      send_sync();
      check("3c_sync_found", 32'(bus.sync_found), 1);
      send_bit(1'b0, 1'b0);
      send_bit(1'b0, 1'b0);
      send_bit(1'b1, 1'b0);
      send_bit(1'b1, 1'b0);
      send_bit(1'b1, 1'b0);
      send_bit(1'b1, 1'b0);
      send_bit(1'b0, 1'b0);
      check("3c_no_br_7bits", 32'(bus.byte_ready), 0);
      send_bit(1'b0, 1'b0);
      check("3c_byte_ready", 32'(bus.byte_ready), 1);
      check("3c_rx_data",    32'(bus.rx_data),    32'h3C);
      send_bit(1'b0, 1'b1);
      check("3c_packet_done", 32'(bus.packet_done), 1);
      check("3c_rx_error",    32'(bus.rx_error),    0);
      send_bit(1'b0, 1'b0);

      // Sync timeout: 16 zeros never form the sync pattern
      repeat (15) send_bit(1'b0, 1'b0);
      check("to_before_limit", 32'(bus.rx_error), 0);
      send_bit(1'b0, 1'b0);
      check("to_rx_error",  32'(bus.rx_error),  1);
      check("to_receiving", 32'(bus.receiving), 1);
      send_bit(1'b1, 1'b0);
      check("to_error_ignores", 32'(bus.receiving), 1);
      send_bit(1'b0, 1'b1);
      check("to_eop_wait", 32'(bus.receiving), 0);
      send_bit(1'b0, 1'b0);

      // EOP during sync search flags an error
      send_bit(1'b0, 1'b0);
      send_sync();
      send_byte(8'h00);
      send_bit(1'b0, 1'b1);
      check("clean_after_to", 32'(bus.rx_error), 0);
      send_bit(1'b0, 1'b0);
      send_bit(1'b0, 1'b0);
      send_bit(1'b0, 1'b0);
      send_bit(1'b0, 1'b1);
      check("sync_eop_error", 32'(bus.rx_error),  1);
      check("sync_eop_wait",  32'(bus.receiving), 0);
      send_bit(1'b0, 1'b0);

      @(negedge clk);
      check("br_pd_overlap", overlap_cnt, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
